// File: rtl/mem_inspect_pkg.sv
// -----------------------------------------------------------------------------
// mem_inspect_pkg
// Shared types and constants for the front-panel memory inspector.
//   panel_state_t : panel bus/convert sequencer states
//   bcd_digit_t   : one BCD digit
//   WB_SEL_ALL    : byte-select used for every panel access
//   DISP_BITS     : width of the displayed data byte
//   add3()        : double-dabble digit correction
// -----------------------------------------------------------------------------
package mem_inspect_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_CONV  = 3'd4
    } panel_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [3:0] WB_SEL_ALL = 4'b1111;
    localparam int         DISP_BITS  = 8;

    // A digit of 5 or more would overflow past 9 after the next left shift.
    function automatic bcd_digit_t add3(input bcd_digit_t d);
        return (d >= 4'd5) ? bcd_digit_t'(d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/mem_inspect_panel_btn_pulse.sv
// -----------------------------------------------------------------------------
// btn_pulse
// Two-flop synchroniser, counter debouncer and rising-edge detector for one
// raw front-panel button.
// Ports:
//   clk_100mhz    in  clock
//   i_rst         in  asynchronous active-high reset
//   i_btn         in  raw, bouncing button level
//   o_pulse       out one-cycle pulse after each debounced press
// Parameter BOUNCE_CYCLES: consecutive stable cycles needed to accept a level.
// -----------------------------------------------------------------------------
module btn_pulse #(
    parameter int BOUNCE_CYCLES = 4
) (
    input  logic clk_100mhz,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int CNT_W = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_level_d;

    always_ff @(posedge clk_100mhz or posedge i_rst) begin
        if (i_rst) begin
            r_sync    <= 2'b00;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], i_btn};
            r_level_d <= r_level;
            // Count only while the synchronised input disagrees with the
            // accepted level; any return to agreement restarts the window.
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_pulse = r_level & ~r_level_d;

endmodule

// File: rtl/mem_inspect_panel.sv
// -----------------------------------------------------------------------------
// mem_inspect_panel
// Front-panel data-memory inspector/loader between the core's Wishbone data
// port and data memory. Arbitrates bus ownership (core vs panel), steps a
// viewing index with debounced buttons, writes switch bytes, and converts the
// viewed byte to BCD with a sequential double-dabble converter.
//
// Build option: define MEM_INSPECT_WRAP_EN to make the index wrap at both ends;
// by default it saturates at 0 and NUM_LOC-1.
//
// Ports:
//   clk_100mhz, i_rst                 clock, async active-high reset
//   i_run                             core requests the memory bus
//   i_btn_next, i_btn_prev            raw step buttons
//   i_show_result                     view RESULT_ADDR instead of the index
//   i_wr_en, i_wr_data                panel byte write (rising edge acts)
//   i_core_*, o_core_*                core Wishbone side
//   o_mem_*, i_mem_*                  data-memory Wishbone side
//   o_index                           current location index
//   o_bcd, o_bcd_valid                {hundreds,tens,ones} of viewed byte
//   o_core_owns                       bus granted to core
// -----------------------------------------------------------------------------
module mem_inspect_panel
    import mem_inspect_pkg::*;
#(
    parameter int ADDR_W        = 13,
    parameter int NUM_LOC       = 11,
    parameter int BASE_ADDR     = 0,
    parameter int STEP_BYTES    = 4,
    parameter int RESULT_ADDR   = 40,
    parameter int BOUNCE_CYCLES = 4
) (
    input  logic              clk_100mhz,
    input  logic              i_rst,
    input  logic              i_run,
    input  logic              i_btn_next,
    input  logic              i_btn_prev,
    input  logic              i_show_result,
    input  logic              i_wr_en,
    input  logic [7:0]        i_wr_data,
    input  logic              i_core_cyc,
    input  logic              i_core_stb,
    input  logic              i_core_we,
    input  logic [31:0]       i_core_addr,
    input  logic [31:0]       i_core_wdata,
    input  logic [3:0]        i_core_sel,
    output logic              o_core_ack,
    output logic              o_core_stall,
    output logic [31:0]       o_core_rdata,
    output logic              o_mem_cyc,
    output logic              o_mem_stb,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic [3:0]        o_mem_sel,
    input  logic              i_mem_ack,
    input  logic              i_mem_stall,
    input  logic [31:0]       i_mem_rdata,
    output logic [7:0]        o_index,
    output logic [11:0]       o_bcd,
    output logic              o_bcd_valid,
    output logic              o_core_owns
);

    localparam int                DD_W      = 12 + DISP_BITS;
    localparam int                BCNT_W    = $clog2(DISP_BITS);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DISP_BITS - 1);
    localparam logic [7:0]        LAST_IDX  = 8'(NUM_LOC - 1);
    localparam logic [ADDR_W-1:0] RES_ADDR  = ADDR_W'(RESULT_ADDR);

    panel_state_t        r_state;
    panel_state_t        w_state_nxt;
    logic                r_own;
    logic                w_own_nxt;
    logic                w_own_rise;
    logic                w_own_fall;
    logic [7:0]          r_index;
    logic [7:0]          w_index_nxt;
    logic                w_index_chg;
    logic                w_next;
    logic                w_prev;
    logic                r_show_d;
    logic                w_show_chg;
    logic                w_view_chg;
    logic                r_wr_en_d;
    logic                w_wr_rise;
    logic                r_wr_pend;
    logic                r_refresh_pend;
    logic                r_is_write;
    logic [ADDR_W-1:0]   r_txn_addr;
    logic [DISP_BITS-1:0] r_wr_byte;
    logic [31:0]         w_lin_addr;
    logic [ADDR_W-1:0]   w_view_addr;
    logic [DD_W-1:0]     r_dd;
    logic [DD_W-1:0]     w_dd_adj;
    logic [DD_W-1:0]     w_dd_step;
    logic [BCNT_W-1:0]   r_bit_cnt;
    logic [11:0]         r_bcd;
    logic                r_bcd_valid;
    logic                w_p_cyc;
    logic                w_p_stb;
    logic                w_start_rd;
    logic                w_start_wr;
    logic                w_wr_done;
    logic                w_rd_done;
    logic                w_conv_done;
    logic                w_unused_bits;

    // ---------------- button conditioning ----------------
    btn_pulse #(.BOUNCE_CYCLES(BOUNCE_CYCLES)) u_btn_next (
        .clk_100mhz (clk_100mhz),
        .i_rst      (i_rst),
        .i_btn      (i_btn_next),
        .o_pulse    (w_next)
    );

    btn_pulse #(.BOUNCE_CYCLES(BOUNCE_CYCLES)) u_btn_prev (
        .clk_100mhz (clk_100mhz),
        .i_rst      (i_rst),
        .i_btn      (i_btn_prev),
        .o_pulse    (w_prev)
    );

    // ---------------- index stepping ----------------
    always_comb begin
        w_index_nxt = r_index;
        if (!r_own && (w_next ^ w_prev)) begin
            if (w_next) begin
                if (r_index >= LAST_IDX) begin
`ifdef MEM_INSPECT_WRAP_EN
                    w_index_nxt = 8'd0;
`else
                    w_index_nxt = r_index;
`endif
                end else begin
                    w_index_nxt = r_index + 8'd1;
                end
            end else begin
                if (r_index == 8'd0) begin
`ifdef MEM_INSPECT_WRAP_EN
                    w_index_nxt = LAST_IDX;
`else
                    w_index_nxt = r_index;
`endif
                end else begin
                    w_index_nxt = r_index - 8'd1;
                end
            end
        end
    end

    // A blocked (saturated) step leaves the index equal and so requests nothing.
    assign w_index_chg = (w_index_nxt != r_index);
    assign w_show_chg  = (i_show_result != r_show_d);
    assign w_view_chg  = w_index_chg | w_show_chg;
    assign w_wr_rise   = i_wr_en & ~r_wr_en_d;

    assign w_lin_addr  = 32'(BASE_ADDR) + 32'(r_index) * 32'(STEP_BYTES);
    assign w_view_addr = i_show_result ? RES_ADDR : w_lin_addr[ADDR_W-1:0];

    // ---------------- ownership ----------------
    // Grant only while the panel sequencer is idle so an in-flight panel
    // transaction (and its conversion) always finishes first; release only
    // once the core has closed its bus cycle.
    always_comb begin
        w_own_nxt = r_own;
        if (i_run && (r_state == ST_IDLE)) begin
            w_own_nxt = 1'b1;
        end else if (!i_run && !i_core_cyc) begin
            w_own_nxt = 1'b0;
        end
    end

    assign w_own_rise = w_own_nxt & ~r_own;
    assign w_own_fall = r_own & ~w_own_nxt;

    // ---------------- panel sequencer ----------------
    always_ff @(posedge clk_100mhz or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_p_cyc     = 1'b0;
        w_p_stb     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                // i_run also blocks a start so a grant and a panel start can
                // never land on the same edge.
                if (!r_own && !i_run) begin
                    if (r_wr_pend) begin
                        w_state_nxt = ST_WRITE;
                    end else if (r_refresh_pend) begin
                        w_state_nxt = ST_READ;
                    end
                end
            end
            ST_WRITE, ST_READ: begin
                w_p_cyc = 1'b1;
                w_p_stb = 1'b1;
                if (!i_mem_stall) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_p_cyc = 1'b1;
                if (i_mem_ack) begin
                    w_state_nxt = r_is_write ? ST_IDLE : ST_CONV;
                end
            end
            ST_CONV: begin
                if (r_bit_cnt == BCNT_LAST) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_start_wr  = (r_state == ST_IDLE) && (w_state_nxt == ST_WRITE);
    assign w_start_rd  = (r_state == ST_IDLE) && (w_state_nxt == ST_READ);
    assign w_wr_done   = (r_state == ST_WAIT) && i_mem_ack && r_is_write;
    assign w_rd_done   = (r_state == ST_WAIT) && i_mem_ack && !r_is_write;
    assign w_conv_done = (r_state == ST_CONV) && (r_bit_cnt == BCNT_LAST);

    // ---------------- double dabble step ----------------
    always_comb begin
        w_dd_adj = r_dd;
        w_dd_adj[DISP_BITS +: 4]     = add3(r_dd[DISP_BITS +: 4]);
        w_dd_adj[DISP_BITS + 4 +: 4] = add3(r_dd[DISP_BITS + 4 +: 4]);
        w_dd_adj[DISP_BITS + 8 +: 4] = add3(r_dd[DISP_BITS + 8 +: 4]);
        w_dd_step = w_dd_adj << 1;
    end

    // ---------------- control and datapath registers ----------------
    always_ff @(posedge clk_100mhz or posedge i_rst) begin
        if (i_rst) begin
            r_own          <= 1'b0;
            r_index        <= 8'd0;
            r_show_d       <= 1'b0;
            r_wr_en_d      <= 1'b0;
            r_wr_pend      <= 1'b0;
            r_refresh_pend <= 1'b1;
            r_is_write     <= 1'b0;
            r_txn_addr     <= '0;
            r_wr_byte      <= '0;
            r_dd           <= '0;
            r_bit_cnt      <= '0;
            r_bcd          <= 12'd0;
            r_bcd_valid    <= 1'b0;
        end else begin
            r_own     <= w_own_nxt;
            r_index   <= w_index_nxt;
            r_show_d  <= i_show_result;
            r_wr_en_d <= i_wr_en;

            // A rise that arrives while busy stays latched until IDLE takes it.
            if (w_wr_rise) begin
                r_wr_pend <= 1'b1;
            end else if (w_start_wr) begin
                r_wr_pend <= 1'b0;
            end

            // Set wins over clear: a view change during the start of a read
            // must still trigger a fresh read of the new address.
            if (w_view_chg || w_own_fall || w_wr_done) begin
                r_refresh_pend <= 1'b1;
            end else if (w_start_rd) begin
                r_refresh_pend <= 1'b0;
            end

            if (w_start_wr || w_start_rd) begin
                r_txn_addr <= w_view_addr;
                r_is_write <= w_start_wr;
                r_wr_byte  <= i_wr_data;
            end

            if (w_rd_done) begin
                r_dd      <= {12'd0, i_mem_rdata[DISP_BITS-1:0]};
                r_bit_cnt <= '0;
            end else if (r_state == ST_CONV) begin
                r_dd      <= w_dd_step;
                r_bit_cnt <= r_bit_cnt + BCNT_W'(1);
            end

            if (w_conv_done) begin
                r_bcd <= w_dd_step[DISP_BITS +: 12];
            end

            // A result computed for an address that has since changed is
            // never flagged valid.
            if (w_view_chg || w_own_rise) begin
                r_bcd_valid <= 1'b0;
            end else if (w_conv_done && !r_refresh_pend) begin
                r_bcd_valid <= 1'b1;
            end
        end
    end

    // ---------------- bus multiplexing ----------------
    assign o_mem_cyc   = r_own ? i_core_cyc               : w_p_cyc;
    assign o_mem_stb   = r_own ? i_core_stb               : w_p_stb;
    assign o_mem_we    = r_own ? i_core_we                : (w_p_cyc & r_is_write);
    assign o_mem_addr  = r_own ? i_core_addr[ADDR_W-1:0]  : (w_p_cyc ? r_txn_addr : '0);
    assign o_mem_wdata = r_own ? i_core_wdata
                               : ((w_p_cyc && r_is_write) ? {24'd0, r_wr_byte} : 32'd0);
    assign o_mem_sel   = r_own ? i_core_sel               : (w_p_cyc ? WB_SEL_ALL : 4'd0);

    assign o_core_ack   = r_own & i_mem_ack;
    assign o_core_stall = r_own ? i_mem_stall : 1'b1;
    assign o_core_rdata = r_own ? i_mem_rdata : 32'd0;

    assign o_index     = r_index;
    assign o_bcd       = r_bcd;
    assign o_bcd_valid = r_bcd_valid;
    assign o_core_owns = r_own;

    // Core address bits above the memory window and the high part of the
    // linear view address are intentionally dropped.
    assign w_unused_bits = ^{i_core_addr, w_lin_addr};

endmodule

// File: tb/tb_mem_inspect_panel.sv
module tb_mem_inspect_panel;

    localparam int ADDR_W      = 13;
    localparam int NUM_LOC     = 11;
    localparam int BASE_ADDR   = 0;
    localparam int STEP_BYTES  = 4;
    localparam int RESULT_ADDR = 40;
    localparam int BOUNCE      = 4;

    logic              clk_100mhz = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_run = 1'b0;
    logic              i_btn_next = 1'b0;
    logic              i_btn_prev = 1'b0;
    logic              i_show_result = 1'b0;
    logic              i_wr_en = 1'b0;
    logic [7:0]        i_wr_data = 8'd0;
    logic              i_core_cyc = 1'b0;
    logic              i_core_stb = 1'b0;
    logic              i_core_we = 1'b0;
    logic [31:0]       i_core_addr = 32'd0;
    logic [31:0]       i_core_wdata = 32'd0;
    logic [3:0]        i_core_sel = 4'd0;
    logic              o_core_ack;
    logic              o_core_stall;
    logic [31:0]       o_core_rdata;
    logic              o_mem_cyc;
    logic              o_mem_stb;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       o_mem_wdata;
    logic [3:0]        o_mem_sel;
    logic              mem_ack;
    logic [31:0]       mem_rdata;
    logic [7:0]        o_index;
    logic [11:0]       o_bcd;
    logic              o_bcd_valid;
    logic              o_core_owns;

    int errors = 0;
    int checks = 0;

    always #5 clk_100mhz = ~clk_100mhz;

    mem_inspect_panel #(
        .ADDR_W(ADDR_W), .NUM_LOC(NUM_LOC), .BASE_ADDR(BASE_ADDR),
        .STEP_BYTES(STEP_BYTES), .RESULT_ADDR(RESULT_ADDR), .BOUNCE_CYCLES(BOUNCE)
    ) dut (
        .clk_100mhz(clk_100mhz), .i_rst(i_rst), .i_run(i_run),
        .i_btn_next(i_btn_next), .i_btn_prev(i_btn_prev),
        .i_show_result(i_show_result), .i_wr_en(i_wr_en), .i_wr_data(i_wr_data),
        .i_core_cyc(i_core_cyc), .i_core_stb(i_core_stb), .i_core_we(i_core_we),
        .i_core_addr(i_core_addr), .i_core_wdata(i_core_wdata), .i_core_sel(i_core_sel),
        .o_core_ack(o_core_ack), .o_core_stall(o_core_stall), .o_core_rdata(o_core_rdata),
        .o_mem_cyc(o_mem_cyc), .o_mem_stb(o_mem_stb), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_sel(o_mem_sel),
        .i_mem_ack(mem_ack), .i_mem_stall(1'b0), .i_mem_rdata(mem_rdata),
        .o_index(o_index), .o_bcd(o_bcd), .o_bcd_valid(o_bcd_valid),
        .o_core_owns(o_core_owns)
    );

    // Wishbone memory model: never stalls, acks ack_dly cycles after the
    // zero-wait case, logs every accepted access.
    logic [31:0]       mem [0:2047];
    int                ack_dly = 0;
    int                ack_cnt;
    logic              busy;
    int                n_reads;
    int                n_writes;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [3:0]        wr_sel;

    always @(posedge clk_100mhz or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 32'd0;
            mem[0]    <= 32'd237;
            mem[2]    <= 32'd7;
            mem[3]    <= 32'd42;
            mem[10]   <= 32'd150;
            busy      <= 1'b0;
            ack_cnt   <= 0;
            mem_ack   <= 1'b0;
            mem_rdata <= 32'd0;
            n_reads   <= 0;
            n_writes  <= 0;
            rd_addr   <= '0;
            wr_addr   <= '0;
            wr_data   <= 32'd0;
            wr_sel    <= 4'd0;
        end else begin
            mem_ack <= 1'b0;
            if (busy) begin
                if (ack_cnt == 0) begin
                    mem_ack <= 1'b1;
                    busy    <= 1'b0;
                end else begin
                    ack_cnt <= ack_cnt - 1;
                end
            end else if (o_mem_cyc && o_mem_stb) begin
                if (o_mem_we) begin
                    for (int b = 0; b < 4; b++)
                        if (o_mem_sel[b]) mem[o_mem_addr[ADDR_W-1:2]][8*b +: 8] <= o_mem_wdata[8*b +: 8];
                    n_writes <= n_writes + 1;
                    wr_addr  <= o_mem_addr;
                    wr_data  <= o_mem_wdata;
                    wr_sel   <= o_mem_sel;
                end else begin
                    n_reads <= n_reads + 1;
                    rd_addr <= o_mem_addr;
                end
                mem_rdata <= mem[o_mem_addr[ADDR_W-1:2]];
                if (ack_dly == 0) begin
                    mem_ack <= 1'b1;
                end else begin
                    busy    <= 1'b1;
                    ack_cnt <= ack_dly - 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic press(input bit nxt);
        if (nxt) i_btn_next = 1'b1;
        else     i_btn_prev = 1'b1;
        repeat (BOUNCE + 6) @(negedge clk_100mhz);
        i_btn_next = 1'b0;
        i_btn_prev = 1'b0;
        repeat (BOUNCE + 26) @(negedge clk_100mhz);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!o_bcd_valid && n < 200) begin
            @(negedge clk_100mhz);
            n++;
        end
        chk(tag, 32'(o_bcd_valid), 32'd1);
    endtask

    initial begin
        int rd0;
        int wr0;
        bit found;

        // reset state
        repeat (3) @(negedge clk_100mhz);
        chk("rst_index",  32'(o_index), 32'd0);
        chk("rst_bcd",    32'(o_bcd), 32'd0);
        chk("rst_valid",  32'(o_bcd_valid), 32'd0);
        chk("rst_cyc",    32'({o_mem_cyc, o_mem_stb, o_mem_we}), 32'd0);
        chk("rst_addr",   32'(o_mem_addr), 32'd0);
        chk("rst_stall",  32'(o_core_stall), 32'd1);
        chk("rst_ack",    32'(o_core_ack), 32'd0);
        chk("rst_rdata",  o_core_rdata, 32'd0);
        chk("rst_owns",   32'(o_core_owns), 32'd0);

        // auto-refresh of address 0 after reset
        i_rst = 1'b0;
        wait_valid("auto_valid");
        chk("auto_bcd",   32'(o_bcd), 32'h237);
        chk("auto_addr",  32'(rd_addr), 32'd0);
        chk("auto_reads", 32'(n_reads), 32'd1);

        // three debounced next presses, one read each
        rd0 = n_reads;
        for (int i = 0; i < 3; i++) press(1'b1);
        chk("next3_index", 32'(o_index), 32'd3);
        chk("next3_addr",  32'(rd_addr), 32'd12);
        chk("next3_reads", 32'(n_reads - rd0), 32'd3);
        chk("next3_bcd",   32'(o_bcd), 32'h042);
        chk("next3_valid", 32'(o_bcd_valid), 32'd1);

        // two-cycle glitch is rejected
        rd0 = n_reads;
        i_btn_next = 1'b1;
        repeat (2) @(negedge clk_100mhz);
        i_btn_next = 1'b0;
        repeat (30) @(negedge clk_100mhz);
        chk("glitch_index", 32'(o_index), 32'd3);
        chk("glitch_reads", 32'(n_reads - rd0), 32'd0);

        // prev to index 2, then panel write of 99 and readback
        press(1'b0);
        chk("prev_index", 32'(o_index), 32'd2);
        chk("prev_bcd",   32'(o_bcd), 32'h007);
        rd0 = n_reads;
        wr0 = n_writes;
        i_wr_data = 8'd99;
        i_wr_en   = 1'b1;
        for (int n = 0; n < 50 && n_writes == wr0; n++) @(negedge clk_100mhz);
        chk("wr_count", 32'(n_writes - wr0), 32'd1);
        chk("wr_addr",  32'(wr_addr), 32'd8);
        chk("wr_data",  wr_data, 32'd99);
        chk("wr_sel",   32'(wr_sel), 32'hF);
        repeat (30) @(negedge clk_100mhz);
        i_wr_en = 1'b0;
        chk("wr_readback_reads", 32'(n_reads - rd0), 32'd1);
        chk("wr_readback_bcd",   32'(o_bcd), 32'h099);
        chk("wr_readback_valid", 32'(o_bcd_valid), 32'd1);

        // ownership request while a panel read waits for a slow ack
        ack_dly    = 3;
        rd0        = n_reads;
        found      = 1'b0;
        i_btn_next = 1'b1;
        for (int n = 0; n < 60 && !found; n++) begin
            @(negedge clk_100mhz);
            if (o_mem_cyc && !o_mem_stb) found = 1'b1;
        end
        chk("own_wait_seen", 32'(found), 32'd1);
        i_run = 1'b1;
        @(negedge clk_100mhz);
        chk("own_stall_in_wait", 32'(o_core_stall), 32'd1);
        chk("own_not_yet",       32'(o_core_owns), 32'd0);
        for (int n = 0; n < 60 && !o_core_owns; n++) @(negedge clk_100mhz);
        i_btn_next = 1'b0;
        chk("own_granted",    32'(o_core_owns), 32'd1);
        chk("own_read_done",  32'(n_reads - rd0), 32'd1);
        chk("own_index",      32'(o_index), 32'd3);
        chk("own_valid_drop", 32'(o_bcd_valid), 32'd0);
        chk("own_stall_free", 32'(o_core_stall), 32'd0);

        // core write passes through unaltered
        ack_dly      = 0;
        i_core_cyc   = 1'b1;
        i_core_stb   = 1'b1;
        i_core_we    = 1'b1;
        i_core_addr  = 32'h0000_0064;
        i_core_wdata = 32'hDEAD_BEEF;
        i_core_sel   = 4'b0011;
        #1;
        chk("core_addr",  32'(o_mem_addr), 32'h64);
        chk("core_wdata", o_mem_wdata, 32'hDEAD_BEEF);
        chk("core_sel",   32'(o_mem_sel), 32'b0011);
        chk("core_ctl",   32'({o_mem_cyc, o_mem_stb, o_mem_we}), 32'b111);
        @(negedge clk_100mhz);
        i_core_stb = 1'b0;
        #1;
        chk("core_ack", 32'(o_core_ack), 32'd1);
        i_core_cyc = 1'b0;
        i_core_we  = 1'b0;
        @(negedge clk_100mhz);
        chk("core_mem", mem[25], 32'h0000_BEEF);

        // index held while the core owns the bus
        press(1'b1);
        chk("own_index_held", 32'(o_index), 32'd3);

        // hand the bus back: panel refreshes the view
        i_run = 1'b0;
        wait_valid("release_valid");
        chk("release_owns", 32'(o_core_owns), 32'd0);
        chk("release_bcd",  32'(o_bcd), 32'h042);

        // show-result override and return
        i_show_result = 1'b1;
        @(negedge clk_100mhz);
        chk("show_valid_drop", 32'(o_bcd_valid), 32'd0);
        wait_valid("show_valid");
        chk("show_addr", 32'(rd_addr), 32'd40);
        chk("show_bcd",  32'(o_bcd), 32'h150);
        i_show_result = 1'b0;
        @(negedge clk_100mhz);
        chk("unshow_valid_drop", 32'(o_bcd_valid), 32'd0);
        wait_valid("unshow_valid");
        chk("unshow_addr", 32'(rd_addr), 32'd12);
        chk("unshow_bcd",  32'(o_bcd), 32'h042);

        // boundaries
        for (int i = 0; i < 7; i++) press(1'b1);
        chk("top_index", 32'(o_index), 32'd10);
        chk("top_bcd",   32'(o_bcd), 32'h150);
        rd0 = n_reads;
        press(1'b1);
`ifdef MEM_INSPECT_WRAP_EN
        chk("wrap_next_index", 32'(o_index), 32'd0);
        chk("wrap_next_bcd",   32'(o_bcd), 32'h237);
        press(1'b0);
        chk("wrap_prev_index", 32'(o_index), 32'd10);
        chk("wrap_prev_bcd",   32'(o_bcd), 32'h150);
`else
        chk("sat_next_index", 32'(o_index), 32'd10);
        chk("sat_next_reads", 32'(n_reads - rd0), 32'd0);
        for (int i = 0; i < 10; i++) press(1'b0);
        chk("bottom_index", 32'(o_index), 32'd0);
        chk("bottom_bcd",   32'(o_bcd), 32'h237);
        rd0 = n_reads;
        press(1'b0);
        chk("sat_prev_index", 32'(o_index), 32'd0);
        chk("sat_prev_reads", 32'(n_reads - rd0), 32'd0);
`endif

        // asynchronous reset in the middle of a panel transaction
        i_show_result = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk_100mhz);
            if (o_mem_cyc) found = 1'b1;
        end
        chk("arst_txn_seen", 32'(found), 32'd1);
        #2;
        i_rst = 1'b1;
        #1;
        chk("arst_cyc",   32'({o_mem_cyc, o_mem_stb}), 32'd0);
        chk("arst_index", 32'(o_index), 32'd0);
        chk("arst_valid", 32'(o_bcd_valid), 32'd0);
        chk("arst_stall", 32'(o_core_stall), 32'd1);
        @(negedge clk_100mhz);
        i_rst = 1'b0;
        wait_valid("arst_refresh_valid");
        chk("arst_refresh_addr", 32'(rd_addr), 32'd40);
        chk("arst_refresh_bcd",  32'(o_bcd), 32'h150);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
